// File: rtl/joy_serial_scanner.sv
// Serial joystick reader: scans a 74HC165 chain, debounces each port, remaps to active-low joystick bytes. Debounce built when JOY_SCANNER_DEBOUNCE_EN is defined.
// Latency: joy_out is re-evaluated once per scan, every (2*NUM_PORTS*BITS_PER_PORT+2)*CLK_DIV clk cycles, on the scan_done edge.
// Backpressure: none; the scanner free-runs and its outputs are always valid.
module joy_serial_scanner #(
    parameter int NUM_PORTS      = 2,
    parameter int BITS_PER_PORT  = 8,
    parameter int CLK_DIV        = 16,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   joy_clk,
    output logic                   joy_load,
    input  logic                   joy_data,
    output logic [8*NUM_PORTS-1:0] joy_out,
    output logic                   scan_done
);

    localparam int TOTAL = NUM_PORTS * BITS_PER_PORT;
    localparam int KW    = $clog2(TOTAL + 1);
    localparam int DW    = $clog2(CLK_DIV);

    if (NUM_PORTS < 1 || NUM_PORTS > 4 || BITS_PER_PORT < 6 || CLK_DIV < 2 || DEBOUNCE_SCANS < 1) begin : g_bad_params
        $error("joy_serial_scanner: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_UPDATE
    } state_t;

    state_t                       state;
    logic [DW-1:0]                div;
    logic                         tick;
    logic                         update;
    logic [KW-1:0]                bit_cnt;
    logic [TOTAL-1:0]             raw;
    logic [NUM_PORTS-1:0][7:0]    cur_byte;
    logic [NUM_PORTS-1:0]         commit;

    assign tick   = (div == DW'(CLK_DIV - 1));
    assign update = tick && (state == S_UPDATE);

    // Chain outputs follow the state one clk later, so joy_load stays low
    // for exactly one tick and joy_clk rises once per captured bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div       <= '0;
            state     <= S_LOAD;
            bit_cnt   <= '0;
            raw       <= '1;
            joy_clk   <= 1'b0;
            joy_load  <= 1'b1;
            scan_done <= 1'b0;
        end else begin
            div       <= tick ? '0 : div + DW'(1);
            joy_load  <= (state != S_LOAD);
            joy_clk   <= (state == S_HIGH);
            scan_done <= update;
            if (tick) begin
                case (state)
                    S_LOAD: begin
                        bit_cnt <= '0;
                        state   <= S_LOW;
                    end
                    S_LOW: begin
                        // Shifting in from the top leaves the first sampled bit at raw[0].
                        raw     <= {joy_data, raw[TOTAL-1:1]};
                        bit_cnt <= bit_cnt + KW'(1);
                        state   <= S_HIGH;
                    end
                    S_HIGH:   state <= (bit_cnt < KW'(TOTAL)) ? S_LOW : S_UPDATE;
                    S_UPDATE: state <= S_LOAD;
                    default:  state <= S_LOAD;
                endcase
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        localparam int B = p * BITS_PER_PORT;
        logic [7:0] out_q;

        assign cur_byte[p] = {2'b11, raw[B+5], raw[B+4], raw[B+0], raw[B+1], raw[B+2], raw[B+3]};

`ifdef JOY_SCANNER_DEBOUNCE_EN
        localparam int             CW   = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
        localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_SCANS - 1);
        logic [7:0]    prev_byte;
        logic [CW-1:0] db_cnt;
        logic [CW-1:0] cnt_nxt;

        assign cnt_nxt   = (cur_byte[p] != prev_byte) ? '0 :
                           (db_cnt == LAST)           ? LAST : db_cnt + CW'(1);
        assign commit[p] = (cnt_nxt == LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                prev_byte <= 8'hFF;
                db_cnt    <= '0;
            end else if (update) begin
                prev_byte <= cur_byte[p];
                db_cnt    <= cnt_nxt;
            end
        end
`else
        assign commit[p] = 1'b1;
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_q <= 8'hFF;
            end else if (update && commit[p]) begin
                out_q <= cur_byte[p];
            end
        end

        assign joy_out[8*p +: 8] = out_q;
    end

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Bench for joy_serial_scanner: chain models feed known raw patterns; a scan-history model predicts joy_out.
module tb_joy_serial_scanner;

    localparam int NP     = 2;
    localparam int BPP    = 8;
    localparam int CD     = 16;
    localparam int DS     = 3;
    localparam int TOT    = NP * BPP;
    localparam int PERIOD = (2 * TOT + 2) * CD;
`ifdef JOY_SCANNER_DEBOUNCE_EN
    localparam int DSE = DS;
    localparam logic [15:0] GLITCH_EXP = 16'hFFFF;
`else
    localparam int DSE = 1;
    localparam logic [15:0] GLITCH_EXP = 16'hDFFF;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Main DUT, default parameters.
    logic        joy_clk, joy_load, joy_data, scan_done;
    logic [15:0] joy_out;
    logic [TOT-1:0] pat = '1;
    logic [TOT-1:0] shreg;

    joy_serial_scanner #(.NUM_PORTS(NP), .BITS_PER_PORT(BPP), .CLK_DIV(CD), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .reset(reset), .joy_clk(joy_clk), .joy_load(joy_load),
        .joy_data(joy_data), .joy_out(joy_out), .scan_done(scan_done));

    always @(negedge joy_load or posedge joy_clk) begin
        if (!joy_load) shreg <= pat;
        else           shreg <= {1'b1, shreg[TOT-1:1]};
    end
    assign joy_data = shreg[0];

    // Second DUT: four ports, fast divider, no debounce; port3 raw[2] held low.
    logic        joy_clk2, joy_load2, joy_data2, scan_done2;
    logic [31:0] joy_out2;
    logic [31:0] pat2 = ~(32'h1 << 26);
    logic [31:0] shreg2;

    joy_serial_scanner #(.NUM_PORTS(4), .BITS_PER_PORT(8), .CLK_DIV(4), .DEBOUNCE_SCANS(1)) dut2 (
        .clk(clk), .reset(reset), .joy_clk(joy_clk2), .joy_load(joy_load2),
        .joy_data(joy_data2), .joy_out(joy_out2), .scan_done(scan_done2));

    always @(negedge joy_load2 or posedge joy_clk2) begin
        if (!joy_load2) shreg2 <= pat2;
        else            shreg2 <= {1'b1, shreg2[31:1]};
    end
    assign joy_data2 = shreg2[0];

    // Per-scan activity counters for the main DUT.
    int lc, ec, cyc, last_lc, last_ec, last_per;
    logic pjc;
    always @(posedge clk) begin
        if (reset) begin
            lc = 0; ec = 0; cyc = 0; pjc = 1'b0;
            last_lc = -1; last_ec = -1; last_per = -1;
        end else begin
            cyc++;
            if (!joy_load) lc++;
            if (joy_clk && !pjc) ec++;
            pjc = joy_clk;
            if (scan_done) begin
                last_lc = lc; last_ec = ec; last_per = cyc;
                lc = 0; ec = 0; cyc = 0;
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: a port commits once its last DSE scanned bytes agree;
    // history is seeded with one all-ones byte, matching the reset state.
    logic [7:0] hist [NP][$];
    logic [7:0] mexp [NP];

    function automatic logic [7:0] remap(input logic [TOT-1:0] r, input int port);
        int src [6] = '{3, 2, 1, 0, 4, 5};
        logic [7:0] b = 8'hFF;
        for (int j = 0; j < 6; j++) b[j] = r[port*BPP + src[j]];
        return b;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            hist[p].delete();
            hist[p].push_back(8'hFF);
            mexp[p] = 8'hFF;
        end
    endtask

    task automatic model_step(input logic [TOT-1:0] r);
        for (int p = 0; p < NP; p++) begin
            logic [7:0] b;
            bit same;
            b = remap(r, p);
            hist[p].push_back(b);
            while (hist[p].size() > DSE) void'(hist[p].pop_front());
            same = (hist[p].size() == DSE);
            foreach (hist[p][i]) if (hist[p][i] != b) same = 0;
            if (same) mexp[p] = b;
        end
    endtask

    function automatic logic [15:0] model_out();
        return {mexp[1], mexp[0]};
    endfunction

    task automatic wait_scan(input string nm);
        logic [15:0] held;
        bit moved, seen;
        held = joy_out; moved = 0; seen = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(negedge clk);
            if (scan_done) begin
                seen = 1;
                break;
            end
            if (joy_out !== held) moved = 1;
        end
        chk({nm, " scan_done"}, 32'(seen), 32'd1);
        chk({nm, " joy_out stable mid-scan"}, 32'(moved), 32'd0);
    endtask

    task automatic run_scan(input logic [TOT-1:0] r, input string nm);
        pat = r;
        wait_scan(nm);
        model_step(r);
        chk({nm, " joy_out"}, 32'(joy_out), 32'(model_out()));
    endtask

    typedef struct {
        logic [15:0] raw;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [7];

    initial begin
        int n;
        bit seen;
        logic [15:0] rp;

        tbl[0] = '{16'hFFFF, 16'hFFFF};
        tbl[1] = '{16'hFFFE, 16'hFFF7};
        tbl[2] = '{16'hFDEF, 16'hFBEF};
        tbl[3] = '{16'hDFFF, 16'hDFFF};
        tbl[4] = '{16'h3F3F, 16'hFFFF};
        tbl[5] = '{16'h0000, 16'hC0C0};
        tbl[6] = '{16'hF7FD, 16'hFEFB};

        model_reset();
        pat = '1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset joy_out", 32'(joy_out), 32'hFFFF);
        chk("reset joy_load", 32'(joy_load), 32'd1);
        chk("reset joy_clk", 32'(joy_clk), 32'd0);
        chk("reset scan_done", 32'(scan_done), 32'd0);
        chk("reset joy_out2", joy_out2, 32'hFFFF_FFFF);
        reset = 1'b0;

        // Four-port instance: first scan commits directly.
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); n++; #1;
            if (scan_done2) break;
        end
        chk("dut2 first scan cycles", 32'(n), 32'd264);
        chk("dut2 joy_out", joy_out2, 32'hFDFF_FFFF);

        for (int s = 0; s < 4; s++) begin
            run_scan('1, "idle");
            if (s >= 2) begin
                chk("scan period", 32'(last_per), 32'(PERIOD));
                chk("joy_load low clks", 32'(last_lc), 32'd16);
                chk("joy_clk rising edges", 32'(last_ec), 32'd16);
            end
        end

        foreach (tbl[i]) begin
            for (int s = 0; s < 3; s++) run_scan(tbl[i].raw, "table");
            chk("table settled", 32'(joy_out), 32'(tbl[i].exp));
        end

        // Single-scan F2 press on port1.
        for (int s = 0; s < 3; s++) run_scan('1, "glitch settle");
        run_scan(16'hDFFF, "glitch");
        chk("glitch joy_out", 32'(joy_out), 32'(GLITCH_EXP));
        run_scan('1, "glitch release");
        chk("glitch released", 32'(joy_out), 32'hFFFF);

        // Both ports pressed, then release port0 only.
        for (int s = 0; s < 3; s++) run_scan(16'hFDEF, "both");
        chk("both pressed", 32'(joy_out), 32'hFBEF);
        for (int s = 0; s < 3; s++) begin
            run_scan(16'hFDFF, "release p0");
            chk("port1 unaffected", 32'(joy_out[15:8]), 32'hFB);
        end
        chk("port0 released", 32'(joy_out), 32'hFBFF);

        // Reset asserted while the chain clock is high.
        for (int s = 0; s < 3; s++) run_scan(16'hFFFE, "pre-reset");
        chk("pre-reset joy_out", 32'(joy_out), 32'hFFF7);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (joy_clk) begin
                seen = 1;
                break;
            end
        end
        chk("reached S_HIGH", 32'(seen), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid-scan reset joy_clk", 32'(joy_clk), 32'd0);
        chk("mid-scan reset joy_load", 32'(joy_load), 32'd1);
        chk("mid-scan reset joy_out", 32'(joy_out), 32'hFFFF);
        chk("mid-scan reset scan_done", 32'(scan_done), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 2 * PERIOD; i++) begin
            @(posedge clk); n++; #1;
            if (scan_done) break;
        end
        chk("first scan after reset cycles", 32'(n), 32'(PERIOD));
        model_step(pat);
        chk("first scan after reset joy_out", 32'(joy_out), 32'(model_out()));
        @(posedge clk); #1;
        for (int s = 0; s < 2; s++) run_scan(16'hFFFE, "post-reset");
        chk("post-reset settled", 32'(joy_out), 32'hFFF7);

        // Random per-port patterns, each port often repeating its last value.
        rp = '1;
        for (int s = 0; s < 20; s++) begin
            for (int p = 0; p < NP; p++) begin
                if ($urandom_range(1, 0) == 1) rp[p*8 +: 8] = 8'($urandom | $urandom);
            end
            run_scan(rp, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/joy_serial_scanner.md
Name: joy_serial_scanner

Overview:
- Multi-port serial joystick reader for board top levels that receive joysticks through a 74HC165-style parallel-in/serial-out shift-register chain on JOY_CLK/JOY_LOAD/JOY_DATA.
- Periodically loads and shifts in NUM_PORTS x BITS_PER_PORT raw bits, optionally debounces them per port, and remaps each port into the controller's 8-bit active-low joystick byte.
- The output feeds the MCU joy1..joyN inputs directly.

Parameters:
- NUM_PORTS, 2: number of joystick ports in the chain (1..4).
- BITS_PER_PORT, 8: raw bits shifted per port (>=6; only bits 0..5 are used).
- CLK_DIV, 16: clk cycles per tick (>=2); every FSM state lasts exactly one tick.
- DEBOUNCE_SCANS, 3: consecutive identical scans required before a port's output changes (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- joy_clk  out  1  shift clock to the chain
- joy_load  out  1  active-low parallel load to the chain
- joy_data  in  1  serial data from the chain; active-low buttons
- joy_out  out  8*NUM_PORTS  port p occupies joy_out[8p+7:8p]; active-low; {2'b11, F2, F1, U, D, L, R}
- scan_done  out  1  one-clk pulse when joy_out is evaluated after a completed scan

Behaviour:
- Reset values (asynchronous, any time including mid-scan): joy_clk=0, joy_load=1, joy_out all ones, scan_done=0, divider=0, FSM=S_LOAD, bit counter=0, debounce counters=0, previous-scan registers all ones.
- Divider: counts 0..CLK_DIV-1 and asserts an internal tick on the cycle it equals CLK_DIV-1. The FSM advances only on ticks.
- TOTAL = NUM_PORTS*BITS_PER_PORT.
- S_LOAD: joy_load=0, joy_clk=0. Next state S_LOW.
- S_LOW: joy_load=1, joy_clk=0. On the tick ending the state, joy_data is captured as raw[k], where k is the bit counter; the counter then increments. Next state S_HIGH.
- S_HIGH: joy_clk=1. Next state is S_LOW if k<TOTAL, otherwise S_UPDATE.
- S_UPDATE: joy_clk=0, joy_load=1. On its ending tick, debounce and remap are evaluated, joy_out is updated on that same edge, and scan_done=1 for that single clk. Next state S_LOAD.
- Scan period: (2*TOTAL+2)*CLK_DIV clk cycles; 544 with the defaults.
- The first sampled bit is raw[0]. Port p uses raw bits b = p*BITS_PER_PORT + i.
- Remap for each port: out[3:0] = {raw[b+0], raw[b+1], raw[b+2], raw[b+3]}, i.e. out[0]=raw[b+3]; out[4]=raw[b+4]; out[5]=raw[b+5]; out[7:6]=2'b11. Bits i>=6 are sampled and discarded.
- Debounce, per port, on the S_UPDATE tick:
  - If the remapped byte equals that port's previous-scan byte, its counter increments, saturating at DEBOUNCE_SCANS-1. Otherwise the counter is 0.
  - The previous-scan byte is always updated with the current byte.
  - When counter == DEBOUNCE_SCANS-1 after the update, joy_out for the port takes the current byte.
  - With DEBOUNCE_SCANS=1, every scan commits immediately.
- Ports debounce independently. A change on one port never delays another port.
- joy_out only changes on the scan_done edge.

Optional Feature:
- JOY_SCANNER_DEBOUNCE_EN.
- Defined: debounce behaves as described above.
- Undefined: counters and previous-scan registers are not built, and every S_UPDATE commits the remapped bytes directly, equivalent to DEBOUNCE_SCANS=1. Timing and scan_done are unchanged.

Test Plan:
- Defaults, chain model all ones, release reset -> joy_out=16'hFFFF throughout; scan_done pulses every 544 clks; joy_load low for exactly 16 clks per scan; 16 joy_clk rising edges per scan.
- Defaults with debounce enabled, port0 raw[0] held low from scan 1 -> joy_out stays 16'hFFFF after scans 1-2, becomes 16'hFFF7 at scan_done of scan 3.
- Port1 raw[5] (F2) low for a single scan only, debounce enabled -> joy_out never leaves 16'hFFFF. Same stimulus with the macro undefined -> 16'hDFFF for exactly one scan period.
- Both ports pressed: port0 raw[4] low, port1 raw[1] low, stable -> after 3 scans joy_out=16'hFBEF. Release port0 only -> port0 byte returns to FF 3 scans later; port1 is unaffected.
- Assert reset mid-scan during S_HIGH with joy_out=16'hFFF7 -> same cycle: joy_clk=0, joy_load=1, joy_out=16'hFFFF. After release, a full 544-clk scan runs before the first scan_done.
- NUM_PORTS=4, CLK_DIV=4, DEBOUNCE_SCANS=1, port3 raw[2] low -> joy_out[31:24]=8'hFD after the first scan (period 264 clks); other bytes FF.
